// File: rtl/sobel_writer.sv
// Result writer: buffers sobel output lines in a FIFO and issues cache-line write
// requests to a contiguous output buffer, counting write responses until the job completes.
//
// state | meaning
// IDLE  | no job since reset; waiting for start
// RUN   | accepting lines from the core and issuing writes
// DRAIN | all lines issued; waiting for the remaining write responses
// DONE  | every response received; done held until the next start
module sobel_writer #(
    parameter int DEPTH    = 16,
    parameter int AF_SLACK = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [41:0]  base_addr,
    input  logic [31:0]  num_lines,
    input  logic [511:0] data_in,
    input  logic         valid_in,
    input  logic         c1_almfull,
    input  logic         wr_rsp_valid,
    output logic         wr_valid,
    output logic [41:0]  wr_addr,
    output logic [511:0] wr_data,
    output logic [15:0]  wr_mdata,
    output logic         in_almfull,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic [31:0]  lines_acked
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_LEVEL = (AW+1)'(DEPTH - AF_SLACK);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_next;
    logic [511:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic [41:0]   base_q;
    logic [31:0]   num_q, issued;
    logic          start_ok, push_req, push_ok, pop, active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = (num_lines == 32'd0) ? DONE : RUN;
                end
            end
            RUN:     if (issued == num_q) state_next = DRAIN;
            DRAIN:   if (lines_acked == num_q) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // A pop frees a slot in the same cycle, so a push onto a full FIFO still lands.
    always_comb begin
        active   = (state == RUN) || (state == DRAIN);
        pop      = (state == RUN) && (count != '0) && !c1_almfull && (issued < num_q);
        push_req = valid_in && (state == RUN);
        push_ok  = push_req && ((count < FULL) || pop);
        if (start_ok) begin
            count_next = '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   count_next = count + CNT_ONE;
                2'b01:   count_next = count - CNT_ONE;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            base_q      <= '0;
            num_q       <= '0;
            issued      <= '0;
            lines_acked <= '0;
            overflow    <= 1'b0;
            in_almfull  <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_mdata    <= '0;
        end else begin
            count      <= count_next;
            in_almfull <= (count_next >= AF_LEVEL);
            wr_valid   <= pop;
            if (pop) begin
                wr_data  <= mem[rd_ptr];
                wr_addr  <= base_q + {10'd0, issued};
                wr_mdata <= issued[15:0];
            end
            if (start_ok) begin
                base_q      <= base_addr;
                num_q       <= num_lines;
                issued      <= '0;
                lines_acked <= '0;
                overflow    <= 1'b0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    issued <= issued + 32'd1;
                end
                if (push_req && !push_ok) overflow <= 1'b1;
                if (wr_rsp_valid && active && (lines_acked < num_q))
                    lines_acked <= lines_acked + 32'd1;
            end
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

endmodule

// File: doc/sobel_writer.md
SOBEL_WRITER -- requirements
Module: sobel_writer

Interface
REQ-001 Parameter DEPTH, default 16, result FIFO depth in 512-bit lines; SHALL be a power of two and at least 16.
REQ-002 Parameter AF_SLACK, default 8, free FIFO entries that remain when in_almfull asserts.
REQ-003 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse that begins a job.
REQ-007 base_addr  in  42  cache-line address of the output buffer.
REQ-008 num_lines  in  32  number of 512-bit lines in the job.
REQ-009 data_in  in  512  result line from the sobel core.
REQ-010 valid_in  in  1  data_in qualifier; there is no backpressure to the core.
REQ-011 c1_almfull  in  1  write channel almost-full.
REQ-012 wr_rsp_valid  in  1  one write response (one line).
REQ-013 wr_valid  out  1  write request strobe.
REQ-014 wr_addr  out  42  write cache-line address.
REQ-015 wr_data  out  512  write payload.
REQ-016 wr_mdata  out  16  line index, low 16 bits.
REQ-017 in_almfull  out  1  throttle to the requestor read issue.
REQ-018 busy  out  1  job in progress.
REQ-019 done  out  1  job complete.
REQ-020 overflow  out  1  sticky flag, data lost.
REQ-021 lines_acked  out  32  write responses counted in the current job.

Function
REQ-022 FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-023 On start in IDLE or DONE, the block SHALL:
- latch base_addr and num_lines;
- clear the issued and acked counters, the FIFO and overflow;
- go to RUN, or go directly to DONE if num_lines==0.
REQ-024 start in RUN or DRAIN SHALL be ignored.
REQ-025 valid_in SHALL push into the FIFO only in RUN; in any other state the data is discarded without setting overflow.
REQ-026 A push SHALL be accepted if count<DEPTH or a pop occurs in the same cycle.
REQ-027 If a push is refused, the data SHALL be dropped and overflow set, held until the next accepted start.
REQ-028 A pop SHALL occur in RUN when all of the following hold: FIFO not empty, c1_almfull==0, issued<num_lines.
REQ-029 wr_valid SHALL be registered and asserted exactly one cycle per pop, in the cycle after the pop, together with:
- wr_data = the popped line;
- wr_addr = base_addr + issued (42-bit, wrapping modulo 2^42);
- wr_mdata = issued[15:0].
REQ-030 The issued counter SHALL increment on each pop.
REQ-031 Minimum latency SHALL be 2 cycles: valid_in at cycle t gives wr_valid at t+2 when the FIFO was empty and c1_almfull stayed low.
REQ-032 c1_almfull rising SHALL stop pops from the next cycle; at most one wr_valid may follow its assertion.
REQ-033 in_almfull SHALL be a registered signal equal to (count >= DEPTH-AF_SLACK).
REQ-034 RUN SHALL transition to DRAIN in the cycle after issued reaches num_lines.
REQ-035 Lines still in the FIFO beyond num_lines SHALL remain unissued and be flushed by the next start.
REQ-036 lines_acked SHALL increment on wr_rsp_valid in RUN or DRAIN and SHALL saturate at num_lines; responses in IDLE or DONE SHALL be ignored.
REQ-037 DRAIN SHALL transition to DONE when lines_acked==num_lines.
REQ-038 done SHALL be 1 only in DONE and SHALL hold until the next start.
REQ-039 busy SHALL be 1 in RUN and DRAIN.
REQ-040 When valid_in and a pop coincide on a full FIFO, count SHALL remain DEPTH and no data SHALL be lost.

Reset
REQ-041 Asserting reset SHALL, asynchronously, set: state=IDLE, FIFO empty, all counters 0, wr_valid=0, in_almfull=0, busy=0, done=0, overflow=0, lines_acked=0.
REQ-042 wr_addr, wr_data and wr_mdata SHALL be 0 after reset.
REQ-043 Reset asserted mid-job SHALL abandon the job; responses arriving after reset release SHALL be ignored (state IDLE).

Verification
REQ-044 base 0x100, num_lines 4, four valid_in back-to-back, c1_almfull=0 -> wr_valid at t+2..t+5, addr 0x100..0x103, mdata 0..3; 4 responses -> done=1, lines_acked=4.
REQ-045 num_lines 0 start -> done=1 the next cycle, wr_valid never asserted.
REQ-046 c1_almfull=1 while 20 lines are pushed (DEPTH 16) -> in_almfull set at count 8, overflow=1 at the 17th push, exactly 16 writes issued after c1_almfull drops.
REQ-047 base 0x3FF_FFFF_FFFF, num_lines 2 -> wr_addr 0x3FF_FFFF_FFFF then 0x000_0000_0000.
REQ-048 reset driven low in DRAIN with 2 of 4 responses outstanding -> all outputs at reset values immediately; late responses leave lines_acked=0 and done=0.
REQ-049 start pulsed in RUN -> ignored: base and count unchanged, the job completes normally.
